mod_dec_invshifter: RTL and testbench
=====================================

// Module: mod_dec_invshifter
// PURPOSE
//  InvShiftRows stage of the AES-256 decryption datapath; it is the inverse of the encryption shifter.
//  - Accepts the 128-bit state one row (4 bytes) per beat, row 0 first.
//  - Rotates row r right by r byte positions and buffers results in a 2-entry output FIFO.
//  - Valid/ready on both sides. Sits between the inverse-cipher round input and InvSubBytes.
// PARAMETERS
//  N      4  bytes per row; only 4 is legal (elaboration error otherwise)
//  DEPTH  2  output FIFO entries; legal range 1..4
// PORTS
//  clk        in   1        rising-edge clock
//  resetn     in   1        asynchronous, ACTIVE-HIGH reset despite the codebase name; 1 = reset
//  clr        in   1        synchronous flush and row realign; 1-cycle pulse
//  in_valid   in   1        inp holds a row
//  in_ready   out  1        block can accept a row this cycle
//  inp        in   N x 8    row bytes; inp[0] is the column-0 byte
//  out_valid  out  1        outp/out_row are valid
//  out_ready  in   1        consumer takes outp this cycle
//  outp       out  N x 8    inverse-shifted row, FIFO head
//  out_row    out  2        row index of outp (0..3)
//  done       out  1        1-cycle pulse: row 3 of a block has left the block
// BEHAVIOUR
//  Reset values (resetn=1, asynchronous)
//  - row counter = 0, FIFO count = 0, FIFO storage = 0.
//  - outp = 0, out_row = 0, out_valid = 0, in_ready = 0, done = 0.
//  - in_ready stays 0 while reset is asserted and rises the first clk edge after release.
//  Handshakes
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH), registered. There is no bypass when full: a simultaneous pop frees space one cycle later.
//  - Push while not full and pop in the same cycle are both honoured; count is unchanged.
//  - in_valid while in_ready=0: the beat is not taken and the row counter does not advance.
//  Transform (input row index r = row counter at push)
//  - outp[i] = inp[(i - r) mod 4].
//  - r=0: identity. r=1: {inp3,inp0,inp1,inp2}.
//  - r=2: {inp2,inp3,inp0,inp1}. r=3: {inp1,inp2,inp3,inp0}.
//  - The entry stores the rotated bytes plus r.
//  Latency
//  - A row pushed at edge k into an empty FIFO gives out_valid=1 after edge k (1 cycle).
//  - outp and out_row are stable while out_valid=1 and out_ready=0.
//  Row counter
//  - Increments on every push and wraps 3 -> 0. It is not tied to pops.
//  done
//  - Registered: 1 for exactly the cycle after the pop of an entry with out_row=3, else 0.
//  clr
//  - At the next edge: row counter = 0, count = 0, out_valid = 0, in_ready = 1.
//  - clr has priority: a push or pop in the same cycle is discarded.
//  - done is not generated for a row-3 pop discarded by clr.
//  Mid-operation reset
//  - Async reset at any point discards buffered rows immediately. There is no partial-block recovery.
// STRUCTURE
//  - Package aes_pkg: localparam AES_NB = 4; typedef logic [7:0] aes_byte_t;
//    typedef aes_byte_t [AES_NB-1:0] aes_row_t; typedef logic [1:0] aes_rowidx_t.
//  - Sub-module mod_dec_invshift_rot: combinational, (aes_row_t in, aes_rowidx_t r) -> aes_row_t.
//    The encrypt-side rotate can share its testbench reference model.
//  - FIFO: circular buffer with read/write pointers and a count; entry = {aes_rowidx_t, aes_row_t}.
// TESTING
//  1. Reset: resetn=1 mid-stream with 2 rows buffered -> same cycle out_valid=0, outp=0, done=0.
//     After release, the first push is treated as row 0.
//  2. Block: push rows 00010203, 10111213, 20212223, 30313233 (inp[0..3] bytes), out_ready=1.
//     -> outp = 00010203, 13101112, 22232021, 31323330 on consecutive cycles with out_row 0..3.
//     done=1 only in the cycle after the row-3 pop.
//  3. Backpressure: out_ready=0, push 3 rows with DEPTH=2 -> in_ready=0 after 2 pushes.
//     The third row is held off and the row counter stays at 2. Raise out_ready -> order preserved, no loss.
//  4. Wrap: push 8 rows back-to-back -> out_row sequence 0,1,2,3,0,1,2,3 and two done pulses.
//  5. clr: clr with row 1 buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1.
//     The following push is rotated as row 0.
//  6. Simultaneous push and pop at count=1 for 6 cycles -> count stays 1 and the latency of each row is 1 cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Package: aes_pkg
// Shared AES datapath types: byte, 4-byte row, 2-bit row index, and the
// row-FIFO entry used by the decrypt-side InvShiftRows stage.
`timescale 1ns/1ps
package aes_pkg;

    localparam int AES_NB = 4;

    typedef logic [7:0]              aes_byte_t;
    typedef aes_byte_t [AES_NB-1:0]  aes_row_t;
    typedef logic [1:0]              aes_rowidx_t;

    // One buffered row: rotated bytes tagged with the row index they were rotated as.
    typedef struct packed {
        aes_rowidx_t row;
        aes_row_t    data;
    } aes_fifo_entry_t;

endpackage

// File: rtl/mod_dec_invshift_rot.sv
// Module: mod_dec_invshift_rot
// Combinational inverse row rotate: row_out[i] = row_in[(i - r) mod 4],
// i.e. row r is rotated right by r byte positions.
// Ports:
//   row_in   in   aes_row_t     input row, row_in[0] is the column-0 byte
//   r        in   aes_rowidx_t  row index (rotate amount)
//   row_out  out  aes_row_t     rotated row
`timescale 1ns/1ps
module mod_dec_invshift_rot
    import aes_pkg::*;
(
    input  aes_row_t    row_in,
    input  aes_rowidx_t r,
    output aes_row_t    row_out
);

    always_comb begin
        row_out = '0;
        for (int i = 0; i < AES_NB; i++) begin
            // 2-bit subtraction wraps, giving the mod-4 source index for free.
            row_out[i] = row_in[aes_rowidx_t'(i) - r];
        end
    end

endmodule

// File: rtl/mod_dec_invshifter.sv
// Module: mod_dec_invshifter
// InvShiftRows stage of the AES-256 decrypt datapath. Takes the state one row
// per beat (row 0 first), rotates row r right by r bytes and queues the result
// with its row index in a small circular FIFO.
// Ports:
//   clk        in   1      rising-edge clock
//   resetn     in   1      asynchronous reset, ACTIVE HIGH (1 = reset)
//   clr        in   1      synchronous flush and row realign
//   in_valid   in   1      inp holds a row
//   in_ready   out  1      a row can be accepted this cycle (registered)
//   inp        in   N x 8  row bytes, inp[0] = column 0
//   out_valid  out  1      outp/out_row valid
//   out_ready  in   1      consumer takes outp this cycle
//   outp       out  N x 8  inverse-shifted row at the FIFO head
//   out_row    out  2      row index of outp
//   done       out  1      1-cycle pulse after row 3 of a block is popped
`timescale 1ns/1ps
module mod_dec_invshifter
    import aes_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0][7:0] inp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0][7:0] outp,
    output logic [1:0]        out_row,
    output logic              done
);

    if (N != 4) begin : g_bad_n
        $error("mod_dec_invshifter: N must be 4");
    end
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("mod_dec_invshifter: DEPTH must be in 1..4");
    end

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    aes_fifo_entry_t mem_q [DEPTH];
    ptr_t            wr_ptr_q, rd_ptr_q;
    cnt_t            count_q, count_d;
    aes_rowidx_t     row_q;
    logic            in_ready_q, in_ready_d;
    logic            done_q;
    logic            push, pop;
    aes_row_t        rot_row;
    aes_fifo_entry_t head;

    mod_dec_invshift_rot u_rot (
        .row_in  (aes_row_t'(inp)),
        .r       (row_q),
        .row_out (rot_row)
    );

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
        if (clr) begin
            count_d = '0;
        end
        // Readiness follows the post-edge occupancy, so space freed by a pop
        // when full only becomes visible in the following cycle.
        in_ready_d = (count_d != cnt_t'(DEPTH));
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            row_q      <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            done_q     <= pop & ~clr & (head.row == 2'd3);
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                row_q    <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= '{row: row_q, data: rot_row};
                    wr_ptr_q        <= ptr_inc(wr_ptr_q);
                    row_q           <= row_q + 2'd1;
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
            end
        end
    end

    assign in_ready = in_ready_q;
    assign outp     = head.data;
    assign out_row  = head.row;
    assign done     = done_q;

endmodule

// File: tb/tb_mod_dec_invshifter.sv
`timescale 1ns/1ps
module tb_mod_dec_invshifter;

    logic              clk = 1'b0;
    logic              resetn;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0][7:0]   inp;
    logic              out_valid;
    logic              out_ready;
    logic [3:0][7:0]   outp;
    logic [1:0]        out_row;
    logic              done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod_dec_invshifter #(.N(4), .DEPTH(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp       (inp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outp      (outp),
        .out_row   (out_row),
        .done      (done)
    );

    // Packs bytes in column order: b0 lands in inp[0].
    function automatic logic [31:0] mk(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rows built from bytes C0..C3, rotated as row 0..3.
    logic [31:0] crot [4];

    task automatic test_reset();
        resetn = 1'b1; clr = 0; in_valid = 0; out_ready = 0; inp = '0;
        #12;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_vec++; if (outp !== 32'h0) begin n_err++; $display("FAIL rst_outp got %h want 0", outp); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
        tick();
        resetn = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rel_in_ready_early got %b want 0", in_ready); end
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_block();
        logic [31:0] din [4];
        logic [31:0] dexp [4];
        din[0] = mk(8'h00, 8'h01, 8'h02, 8'h03); dexp[0] = mk(8'h00, 8'h01, 8'h02, 8'h03);
        din[1] = mk(8'h10, 8'h11, 8'h12, 8'h13); dexp[1] = mk(8'h13, 8'h10, 8'h11, 8'h12);
        din[2] = mk(8'h20, 8'h21, 8'h22, 8'h23); dexp[2] = mk(8'h22, 8'h23, 8'h20, 8'h21);
        din[3] = mk(8'h30, 8'h31, 8'h32, 8'h33); dexp[3] = mk(8'h31, 8'h32, 8'h33, 8'h30);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; inp = din[i];
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL blk_valid[%0d] got %b want 1", i, out_valid); end
            n_vec++; if (outp !== dexp[i]) begin n_err++; $display("FAIL blk_outp[%0d] got %h want %h", i, outp, dexp[i]); end
            n_vec++; if (out_row !== 2'(i)) begin n_err++; $display("FAIL blk_row[%0d] got %0d want %0d", i, out_row, i); end
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL blk_done[%0d] got %b want 0", i, done); end
        end
        in_valid = 0;
        tick();
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL blk_done_pulse got %b want 1", done); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL blk_drain got %b want 0", out_valid); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL blk_done_end got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        in_valid = 1; inp = mk(8'h40, 8'h41, 8'h42, 8'h43);
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
        inp = mk(8'h50, 8'h51, 8'h52, 8'h53);
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got %b want 0", in_ready); end
        inp = mk(8'h60, 8'h61, 8'h62, 8'h63);
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_held got %b want 0", in_ready); end
        n_vec++; if (outp !== mk(8'h40, 8'h41, 8'h42, 8'h43) || out_row !== 2'd0) begin
            n_err++; $display("FAIL bp_stable got %h/%0d want 43424140/0", outp, out_row); end
        out_ready = 1;
        tick();
        n_vec++; if (outp !== mk(8'h53, 8'h50, 8'h51, 8'h52) || out_row !== 2'd1) begin
            n_err++; $display("FAIL bp_second got %h/%0d want 52515053/1", outp, out_row); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_freed got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        n_vec++; if (outp !== mk(8'h62, 8'h63, 8'h60, 8'h61) || out_row !== 2'd2) begin
            n_err++; $display("FAIL bp_third got %h/%0d want 61606362/2", outp, out_row); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_clr();
        // Row counter is at 3 here: buffer a row-3 entry, then clear while popping it.
        out_ready = 0; in_valid = 1; inp = mk(8'h80, 8'h81, 8'h82, 8'h83);
        tick();
        n_vec++; if (outp !== mk(8'h81, 8'h82, 8'h83, 8'h80) || out_row !== 2'd3) begin
            n_err++; $display("FAIL clr_row3 got %h/%0d want 80838281/3", outp, out_row); end
        clr = 1; out_ready = 1; inp = mk(8'hEE, 8'hEE, 8'hEE, 8'hEE);
        tick();
        clr = 0; in_valid = 0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr3_valid got %b want 0", out_valid); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL clr3_done got %b want 0", done); end
        // Row 0 then row 1, leaving row 1 buffered.
        in_valid = 1; inp = mk(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        tick();
        inp = mk(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        tick();
        n_vec++; if (out_row !== 2'd1 || outp !== mk(8'hB3, 8'hB0, 8'hB1, 8'hB2)) begin
            n_err++; $display("FAIL clr_pre got %h/%0d want b2b1b0b3/1", outp, out_row); end
        clr = 1; inp = mk(8'hEE, 8'hEE, 8'hEE, 8'hEE);
        tick();
        clr = 0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL clr_ready got %b want 1", in_ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL clr_done got %b want 0", done); end
        out_ready = 0; inp = mk(8'h90, 8'h91, 8'h92, 8'h93);
        tick();
        in_valid = 0;
        n_vec++; if (out_row !== 2'd0 || outp !== mk(8'h90, 8'h91, 8'h92, 8'h93)) begin
            n_err++; $display("FAIL clr_realign got %h/%0d want 93929190/0", outp, out_row); end
        out_ready = 1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_drain got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        clr = 1;
        tick();
        clr = 0; out_ready = 1; in_valid = 1; inp = mk(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        for (int j = 0; j < 9; j++) begin
            if (j == 8) in_valid = 0;
            tick();
            if (j < 8) begin
                n_vec++; if (out_row !== 2'(j % 4) || outp !== crot[j % 4]) begin
                    n_err++; $display("FAIL wrap_row[%0d] got %h/%0d want %h/%0d", j, outp, out_row, crot[j % 4], j % 4); end
            end
            n_vec++; if (done !== (j == 4 || j == 8)) begin
                n_err++; $display("FAIL wrap_done[%0d] got %b want %b", j, done, (j == 4 || j == 8)); end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 0; in_valid = 1; inp = mk(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        tick();
        out_ready = 1;
        for (int j = 0; j < 6; j++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_occ[%0d] got v=%b r=%b want 1/1", j, out_valid, in_ready); end
            n_vec++; if (out_row !== 2'((j + 1) % 4) || outp !== crot[(j + 1) % 4]) begin
                n_err++; $display("FAIL b2b_head[%0d] got %h/%0d want %h/%0d", j, outp, out_row, crot[(j + 1) % 4], (j + 1) % 4); end
            n_vec++; if (done !== (j == 3)) begin
                n_err++; $display("FAIL b2b_done[%0d] got %b want %b", j, done, (j == 3)); end
        end
        in_valid = 0;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_midreset();
        out_ready = 0; in_valid = 1; inp = mk(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        tick();
        tick();
        in_valid = 0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mr_full got %b want 0", in_ready); end
        #2 resetn = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid got %b want 0", out_valid); end
        n_vec++; if (outp !== 32'h0 || out_row !== 2'd0) begin n_err++; $display("FAIL mr_outp got %h/%0d want 0/0", outp, out_row); end
        n_vec++; if (done !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL mr_ctl got d=%b r=%b want 0/0", done, in_ready); end
        tick();
        resetn = 1'b0;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready got %b want 1", in_ready); end
        in_valid = 1; inp = mk(8'h11, 8'h22, 8'h33, 8'h44);
        tick();
        in_valid = 0;
        n_vec++; if (out_row !== 2'd0 || outp !== mk(8'h11, 8'h22, 8'h33, 8'h44)) begin
            n_err++; $display("FAIL mr_row0 got %h/%0d want 44332211/0", outp, out_row); end
    endtask

    initial begin
        crot[0] = mk(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        crot[1] = mk(8'hC3, 8'hC0, 8'hC1, 8'hC2);
        crot[2] = mk(8'hC2, 8'hC3, 8'hC0, 8'hC1);
        crot[3] = mk(8'hC1, 8'hC2, 8'hC3, 8'hC0);
        test_reset();
        test_block();
        test_backpressure();
        test_clr();
        test_wrap();
        test_back_to_back();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
